vga_pmod_monitor: RTL

//  Receive-side checker for the TinyVGA PMOD bus produced by the glyph generator. Samples the 8-bit
//  bus on the pixel clock, locks to hsync/vsync, and measures line/frame timing. Recovers pixel

---
 rtl/vga_pmod_monitor.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_pmod_monitor.sv
// vga_pmod_monitor
//   Receive-side observer for the TinyVGA PMOD bus. Samples the bus on the
//   pixel clock, locks to hsync/vsync, measures line and frame length,
//   recovers active-area pixel coordinates and colour, and computes a
//   CRC-16-CCITT over the active picture of every complete locked frame.
//
//   state   | meaning
//   SEARCH  | waiting for the first frame-aligned line (vph reset)
//   MEASURE | counting clean frames, not yet trusted
//   LOCKED  | timing matches; pixels reported, per-frame CRC produced
//
// Ports
//   clk          pixel clock
//   rst_n        synchronous active-low reset
//   pmod[7:0]    {hsync,B0,G0,R0,vsync,B1,G1,R1}
//   locked       timing matches the parameters
//   pix_valid    active-area pixel on pix_x/pix_y/pix_rgb this cycle
//   pix_x/pix_y  active column/row
//   pix_rgb      {R1,R0,G1,G0,B1,B0}
//   frame_done   one-cycle pulse when frame_crc is updated
//   frame_crc    CRC of the last complete locked frame
//   h_total_meas last measured line length (saturating)
//   v_total_meas last measured frame length in lines (saturating)
//   err          one-cycle pulse on a timing violation while LOCKED
//   err_cnt      saturating violation count
module vga_pmod_monitor #(
  parameter int   H_TOTAL     = 800,
  parameter int   V_TOTAL     = 525,
  parameter int   H_ACTIVE    = 640,
  parameter int   V_ACTIVE    = 480,
  parameter int   H_START     = 144,
  parameter int   V_START     = 34,
  parameter logic H_POL       = 1'b0,
  parameter logic V_POL       = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pmod,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_crc,
  output logic [9:0]  h_total_meas,
  output logic [9:0]  v_total_meas,
  output logic        err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [9:0] PH_MAX  = 10'd1023;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_TOT10 = 10'(V_TOTAL);
  localparam logic [9:0] H_BEG   = 10'(H_START);
  localparam logic [9:0] H_END   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_BEG   = 10'(V_START);
  localparam logic [9:0] V_END   = 10'(V_START + V_ACTIVE);
  localparam logic [7:0] LOCK8   = 8'(LOCK_FRAMES);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == PH_MAX) ? v : v + 10'd1;
  endfunction

  // Bit-serial CCITT update, MSB of the pixel first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [5:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 5; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  state_t      state_q, state_nxt;
  logic [7:0]  s1;
  logic        hs2, vs2;
  logic [9:0]  hph_q, vph_q, hph_cur, vph_cur;
  logic        vrst_q;
  logic [7:0]  good_q, good_nxt;
  logic [15:0] crc_q;

  logic       h_lead, v_lead, vreset, viol, active;
  logic       lock_entry, err_set, done_set;
  logic [5:0] rgb_cur;

  // Phases below belong to the sample currently held in s1.
  assign h_lead  = (s1[7] == H_POL) && (hs2 != H_POL);
  assign v_lead  = (s1[3] == V_POL) && (vs2 != V_POL);
  // A vsync lead arriving together with the hsync lead still aligns this line.
  assign vreset  = h_lead && (vrst_q || v_lead);
  assign hph_cur = h_lead ? 10'd0 : sat_inc(hph_q);
  assign vph_cur = vreset ? 10'd0 : (h_lead ? sat_inc(vph_q) : vph_q);
  assign rgb_cur = {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]};
  assign active  = (hph_cur >= H_BEG) && (hph_cur < H_END) &&
                   (vph_cur >= V_BEG) && (vph_cur < V_END);

  assign viol = (h_lead && (hph_q != H_LAST)) ||
                (hph_cur == PH_MAX) ||
                (vreset && (vph_q != V_LAST)) ||
                (h_lead && !vreset && (vph_cur == V_TOT10));

  assign locked = (state_q == LOCKED);

  always_comb begin
    state_nxt  = state_q;
    good_nxt   = good_q;
    lock_entry = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vreset) begin
          state_nxt = MEASURE;
          good_nxt  = 8'd0;
        end
      end
      MEASURE: begin
        if (viol) begin
          state_nxt = SEARCH;
        end else if (vreset) begin
          if (good_q + 8'd1 == LOCK8) begin
            state_nxt  = LOCKED;
            lock_entry = 1'b1;
          end else begin
            good_nxt = good_q + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (viol) begin
          state_nxt = SEARCH;
          err_set   = 1'b1;
        end else if (vreset) begin
          done_set = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      s1           <= 8'd0;
      hs2          <= 1'b0;
      vs2          <= 1'b0;
      hph_q        <= 10'd0;
      vph_q        <= 10'd0;
      vrst_q       <= 1'b0;
      good_q       <= 8'd0;
      crc_q        <= 16'hFFFF;
      pix_valid    <= 1'b0;
      pix_x        <= 10'd0;
      pix_y        <= 10'd0;
      pix_rgb      <= 6'd0;
      frame_done   <= 1'b0;
      frame_crc    <= 16'd0;
      h_total_meas <= 10'd0;
      v_total_meas <= 10'd0;
      err          <= 1'b0;
      err_cnt      <= 8'd0;
    end else begin
      state_q <= state_nxt;
      good_q  <= good_nxt;
      s1      <= pmod;
      hs2     <= s1[7];
      vs2     <= s1[3];
      hph_q   <= hph_cur;
      vph_q   <= vph_cur;
      vrst_q  <= h_lead ? 1'b0 : (vrst_q | v_lead);

      if (h_lead) h_total_meas <= sat_inc(hph_q);
      if (vreset) v_total_meas <= sat_inc(vph_q);

      // Any frame boundary or abandoned frame restarts the running CRC.
      if (lock_entry || done_set || err_set)
        crc_q <= 16'hFFFF;
      else if ((state_q == LOCKED) && active)
        crc_q <= crc_step(crc_q, rgb_cur);

      pix_valid <= (state_q == LOCKED) && active;
      if ((state_q == LOCKED) && active) begin
        pix_x   <= hph_cur - H_BEG;
        pix_y   <= vph_cur - V_BEG;
        pix_rgb <= rgb_cur;
      end

      frame_done <= done_set;
      if (done_set) frame_crc <= crc_q;

      err <= err_set;
      if (err_set && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
